// File: rtl/fp_pkg.sv
// Shared definitions for the FP front-end: operand width, normalize direction,
// normalizer FSM states and the count-to-distance conversion.
package fp_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef enum logic {
    NORM_LEFT  = 1'b0,
    NORM_RIGHT = 1'b1
  } norm_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

  // Signed distance that makes an LSL shifter undo the normalization:
  // a left normalization is undone by shifting right, hence the negation.
  function automatic logic [WIDTH-1:0] norm_distance(input norm_dir_e d,
                                                     input logic [CNT_W-1:0] c);
    logic [WIDTH-1:0] ext;
    ext = {{(WIDTH-CNT_W){1'b0}}, c};
    return (d == NORM_LEFT) ? (~ext + 16'd1) : ext;
  endfunction

endpackage

// File: rtl/normalizer_seq.sv
// Multi-cycle normalizer: shifts an operand toward the chosen edge in 4-bit or
// 1-bit steps until a set bit lands there, then reports value, count and distance.
module normalizer_seq
  import fp_pkg::*;
#(
  parameter int WIDTH = fp_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       value,
  input  logic                   dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic [CNT_W-1:0]       count,
  output logic [WIDTH-1:0]       distance,
  output logic                   zero
);

  norm_state_e      state, state_next;
  logic [WIDTH-1:0] work, work_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  norm_dir_e        dir_q, dir_q_next;

  logic [WIDTH-1:0] result_next;
  logic [CNT_W-1:0] count_next;
  logic [WIDTH-1:0] distance_next;
  logic             zero_next;

  logic edge_set;
  logic nibble_zero;

  always_comb begin
    if (dir_q == NORM_LEFT) begin
      edge_set    = work[WIDTH-1];
      nibble_zero = (work[WIDTH-1 -: 4] == 4'd0);
    end else begin
      edge_set    = work[0];
      nibble_zero = (work[3:0] == 4'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      dir_q    <= NORM_LEFT;
      result   <= '0;
      count    <= '0;
      distance <= '0;
      zero     <= 1'b0;
    end else begin
      state    <= state_next;
      work     <= work_next;
      cnt      <= cnt_next;
      dir_q    <= dir_q_next;
      result   <= result_next;
      count    <= count_next;
      distance <= distance_next;
      zero     <= zero_next;
    end
  end

  always_comb begin
    state_next    = state;
    work_next     = work;
    cnt_next      = cnt;
    dir_q_next    = dir_q;
    result_next   = result;
    count_next    = count;
    distance_next = distance;
    zero_next     = zero;

    case (state)
      IDLE: begin
        if (in_valid) begin
          work_next  = value;
          dir_q_next = norm_dir_e'(dir);
          cnt_next   = '0;
          if (value == '0) begin
            state_next    = DONE;
            zero_next     = 1'b1;
            result_next   = '0;
            count_next    = 5'd16;
            distance_next = norm_distance(norm_dir_e'(dir), 5'd16);
          end else begin
            state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (edge_set) begin
          state_next    = DONE;
          zero_next     = 1'b0;
          result_next   = work;
          count_next    = cnt;
          distance_next = norm_distance(dir_q, cnt);
        end else if (nibble_zero) begin
          // A nonzero operand has at most 15 zeros, so a nibble step never overshoots.
          work_next = (dir_q == NORM_LEFT) ? (work << 4) : (work >> 4);
          cnt_next  = cnt + 5'd4;
        end else begin
          work_next = (dir_q == NORM_LEFT) ? (work << 1) : (work >> 1);
          cnt_next  = cnt + 5'd1;
        end
      end

      DONE: begin
        if (out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_normalizer_seq.sv
// Directed bench for normalizer_seq: hand-computed results, latency, back-pressure,
// reset mid-operation and a round trip through an LSL shifter model.
module tb_normalizer_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic        dir;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  count;
  logic [15:0] distance;
  logic        zero;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  normalizer_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .count     (count),
    .distance  (distance),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Barrel shifter in LSL mode: positive distance shifts left, negative shifts right logically.
  function automatic logic [15:0] shifter_lsl(input logic [15:0] v, input logic [15:0] d);
    int sd;
    sd = $signed(d);
    if (sd >= 16 || sd <= -16) return 16'h0000;
    if (sd >= 0) return v << sd;
    return v >> (-sd);
  endfunction

  // Accept one operand, wait for out_valid and check outputs and latency.
  // Leaves the DUT in DONE, #1 after a clock edge.
  task automatic start_op(input string tag, input logic [15:0] v, input logic d,
                          input logic [15:0] exp_res, input logic [4:0] exp_cnt,
                          input logic [15:0] exp_dist, input logic exp_zero,
                          input int exp_lat);
    int lat;
    check({tag, ".in_ready"}, in_ready, 1'b1);
    value    = v;
    dir      = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    value    = 16'hDEAD;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"},  lat,      exp_lat);
    check({tag, ".result"},   result,   exp_res);
    check({tag, ".count"},    count,    exp_cnt);
    check({tag, ".distance"}, distance, exp_dist);
    check({tag, ".zero"},     zero,     exp_zero);
    check({tag, ".roundtrip"}, shifter_lsl(result, distance), exp_zero ? 16'h0000 : v);
    $display("op %s: value=%h dir=%0d -> result=%h count=%0d distance=%h zero=%0d lat=%0d",
             tag, v, d, result, count, distance, zero, lat);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    value     = 16'h0000;
    dir       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", {out_valid, in_ready, result, count, distance, zero},
          {1'b0, 1'b1, 16'h0, 5'd0, 16'h0, 1'b0});
    reset = 1'b0;
    @(posedge clk); #1;

    start_op("lz15", 16'h0001, 1'b0, 16'h8000, 5'd15, 16'hFFF1, 1'b0, 8); finish_op("lz15");
    start_op("lz2",  16'h3000, 1'b0, 16'hC000, 5'd2,  16'hFFFE, 1'b0, 4); finish_op("lz2");
    start_op("tz15", 16'h8000, 1'b1, 16'h0001, 5'd15, 16'h000F, 1'b0, 8); finish_op("tz15");
    start_op("z_l",  16'h0000, 1'b0, 16'h0000, 5'd16, 16'hFFF0, 1'b1, 1); finish_op("z_l");
    start_op("z_r",  16'h0000, 1'b1, 16'h0000, 5'd16, 16'h0010, 1'b1, 1); finish_op("z_r");
    start_op("lz0",  16'h8000, 1'b0, 16'h8000, 5'd0,  16'h0000, 1'b0, 2); finish_op("lz0");
    start_op("tz4",  16'h0010, 1'b1, 16'h0001, 5'd4,  16'h0004, 1'b0, 3); finish_op("tz4");
    start_op("tz13", 16'hA000, 1'b1, 16'h0005, 5'd13, 16'h000D, 1'b0, 6); finish_op("tz13");

    // Back-pressure: outputs must hold and in_valid must be ignored while in DONE.
    start_op("bp", 16'h00F0, 1'b0, 16'hF000, 5'd8, 16'hFFF8, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      value    = 16'h0003;
      dir      = 1'b1;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d", i),
            {out_valid, in_ready, result, count, distance, zero},
            {1'b1, 1'b0, 16'hF000, 5'd8, 16'hFFF8, 1'b0});
    end
    // Handshake with in_valid also high: the new operand must not be taken.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp.no_accept", {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
    check("bp.idle_hold", {in_ready, out_valid, result, count}, {1'b1, 1'b0, 16'hF000, 5'd8});

    // Reset during SHIFT cycle 3 of 0x0001.
    value    = 16'h0001;
    dir      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.mid_busy", {in_ready, out_valid}, 2'b00);
    reset = 1'b1;
    #1;
    check("rst.async", {out_valid, in_ready, result, count, distance, zero},
          {1'b0, 1'b1, 16'h0, 5'd0, 16'h0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst.discard", {out_valid, in_ready}, 2'b01);
    start_op("after_rst", 16'h4000, 1'b0, 16'h8000, 5'd1, 16'hFFFF, 1'b0, 3);
    finish_op("after_rst");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
